mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial RAM arbiter; the requester side of the pipeline stall protocol.
- Serves instruction fetch (IF) and data load/store (MEM) over a single 8-bit RAM port.
- Splits each 1/2/4-byte access into byte cycles.
- Raises `if_stall_req_o` / `mem_stall_req_o` toward the stall controller until the access completes.
- Sits between the IF/MEM stages and the top-level RAM pins.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- rdy  input  1  global ready; low freezes the block
- if_req_i  input  1  IF fetch request, held until done
- if_addr_i  input  ADDR_WIDTH  fetch address
- if_data_o  output  32  fetched word
- if_done_o  output  1  one-cycle fetch-complete pulse
- if_stall_req_o  output  1  IF stall request
- mem_req_i  input  1  MEM access request, held until done
- mem_we_i  input  1  1 = store, 0 = load
- mem_len_i  input  3  byte count: 1, 2 or 4
- mem_addr_i  input  ADDR_WIDTH  data address
- mem_wdata_i  input  32  store data, little-endian
- mem_rdata_o  output  32  load data, zero-extended
- mem_done_o  output  1  one-cycle MEM-complete pulse
- mem_stall_req_o  output  1  MEM stall request
- ram_a_o  output  ADDR_WIDTH  RAM byte address
- ram_wr_o  output  1  RAM write strobe
- ram_dout_o  output  8  RAM write byte
- ram_din_i  input  8  RAM read byte, valid one cycle after its address

Behaviour:
- **Reset:** state IDLE, counter 0. All outputs are 0: `ram_a_o`, `ram_wr_o`, `ram_dout_o`, both data outputs, both done outputs. A reset mid-transaction aborts it; no done pulse is issued.
- **States:** IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- **Acceptance (IDLE only):**
  - MEM has priority over IF.
  - If `mem_req_i` is high: go to MEM_WR when `mem_we_i`=1, else MEM_RD. Latch addr, len and wdata.
  - Else if `if_req_i` is high: go to IF_RD with len = 4.
- **Read of n bytes, accepted at edge T:**
  - `ram_a_o` = addr+k during cycle T+k, for k = 0..n-1.
  - Byte k is captured from `ram_din_i` at edge T+k+2 into bits [8k+7:8k].
  - Done is set at edge T+n+1; bytes not read are 0.
  - A 4-byte read therefore completes at T+5.
- **Write of n bytes, accepted at edge T:**
  - `ram_wr_o`=1 and `ram_dout_o` = wdata[8k+7:8k] at addr+k during cycle T+k.
  - Done is set at edge T+n.
  - `ram_wr_o` is 0 in every other cycle.
- **DONE state:**
  - The matching `*_done_o` is high for exactly one cycle, with data valid in that cycle.
  - DONE → IDLE unconditionally. The still-high request is not re-accepted in the DONE cycle.
  - Requesters drop or replace their request at the next edge.
- **Stall requests (combinational):**
  - `if_stall_req_o` = `if_req_i` & ~`if_done_o`.
  - `mem_stall_req_o` = `mem_req_i` & ~`mem_done_o`.
  - An IF request waiting behind a MEM access keeps stalling.
- **Request withdrawal:** `if_req_i` falling during IF_RD (flush) aborts to IDLE at the next edge with no done. `mem_req_i` must stay high for the whole MEM access.
- **rdy low:**
  - State, counter and captured data hold.
  - `ram_wr_o` is forced to 0 and `ram_a_o` holds.
  - A read byte due during the freeze is re-fetched by re-issuing the current address after `rdy` rises.
- **Address arithmetic:** addr+k wraps modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro: `MEMCTRL_IF_ABORT_EN`.
- **Defined:** `mem_req_i` rising during IF_RD aborts the fetch at the next edge (no `if_done_o`). The MEM access is accepted on the following edge from IDLE, and the IF fetch restarts from byte 0 after the MEM access completes.
- **Undefined:** the IF fetch runs to completion before MEM is accepted.

Test Plan:
- Reset mid-IF_RD (byte 2) → next cycle IDLE, `ram_wr_o`=0, no `if_done_o`.
- IF fetch at 0x1000, RAM bytes 13,05,00,00 → `ram_a_o` 0x1000..0x1003 in cycles T..T+3; `if_done_o` at T+5 with `if_data_o`=0x00000513; `if_stall_req_o` high T..T+4.
- Store word 0xDEADBEEF to 0x20, len 4 → writes EF,BE,AD,DE to 0x20..0x23; `mem_done_o` at T+4.
- 1-byte load from 0x7 with `ram_din_i`=0xFF → `mem_rdata_o`=0x000000FF at T+2.
- `if_req_i` and `mem_req_i` both high in IDLE → MEM served first; IF accepted on the edge after DONE and completes 5 cycles later.
- `rdy` low for 3 cycles mid-store (byte 1) → no `ram_wr_o` during the freeze; byte 1 is written once after `rdy` rises; done is delayed 3 cycles. With `MEMCTRL_IF_ABORT_EN`, `mem_req_i` rising at IF byte 1 → IF aborted, MEM done first, IF then refetches all 4 bytes.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter serving IF fetches and MEM loads/stores over one 8-bit port.
// Define MEMCTRL_IF_ABORT_EN to let a MEM request pre-empt an in-flight IF fetch.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  output logic                  if_stall_req_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [2:0]            mem_len_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_stall_req_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);
  // state  | meaning
  // IDLE   | waiting for a request; MEM wins over IF
  // IF_RD  | fetching the 4 instruction bytes
  // MEM_RD | loading len bytes
  // MEM_WR | storing len bytes
  // DONE   | one-cycle done pulse, result valid
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IF_RD  = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            state;
  logic                  done_if;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [2:0]            len;
  logic [2:0]            a_idx;
  logic [2:0]            cap;
  logic [2:0]            prev_idx;
  logic                  prev_vld;
  logic [31:0]           wdata;
  logic [31:0]           if_data_q;
  logic [31:0]           mem_rdata_q;
  logic                  hit;
  logic                  abort_if;
  logic [2:0]            cap_n;
  logic [2:0]            nxt_idx;

`ifdef MEMCTRL_IF_ABORT_EN
  assign abort_if = ~if_req_i | mem_req_i;
`else
  assign abort_if = ~if_req_i;
`endif

  // ram_din_i answers last cycle's address; after a freeze that answer is stale,
  // so the first uncaptured byte's address is issued again.
  assign hit     = prev_vld && (prev_idx == cap);
  assign cap_n   = cap + {2'b00, hit};
  assign nxt_idx = (a_idx == cap_n) ? a_idx + 3'd1 : cap_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      done_if     <= 1'b0;
      base        <= '0;
      a_q         <= '0;
      len         <= 3'd0;
      a_idx       <= 3'd0;
      cap         <= 3'd0;
      prev_idx    <= 3'd0;
      prev_vld    <= 1'b0;
      wdata       <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          a_idx    <= 3'd0;
          cap      <= 3'd0;
          prev_vld <= 1'b0;
          if (mem_req_i) begin
            state   <= mem_we_i ? S_MEM_WR : S_MEM_RD;
            done_if <= 1'b0;
            base    <= mem_addr_i;
            a_q     <= mem_addr_i;
            len     <= mem_len_i;
            wdata   <= mem_wdata_i;
            if (!mem_we_i) mem_rdata_q <= 32'h0;
          end else if (if_req_i) begin
            state     <= S_IF_RD;
            done_if   <= 1'b1;
            base      <= if_addr_i;
            a_q       <= if_addr_i;
            len       <= 3'd4;
            if_data_q <= 32'h0;
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if (state == S_IF_RD && abort_if) begin
            state <= S_IDLE;
          end else begin
            if (hit) begin
              if (state == S_IF_RD) if_data_q[{cap[1:0], 3'b000} +: 8] <= ram_din_i;
              else                  mem_rdata_q[{cap[1:0], 3'b000} +: 8] <= ram_din_i;
            end
            prev_idx <= a_idx;
            prev_vld <= 1'b1;
            a_idx    <= nxt_idx;
            a_q      <= base + ADDR_WIDTH'(nxt_idx);
            cap      <= cap_n;
            if (cap_n == len) state <= S_DONE;
          end
        end
        S_MEM_WR: begin
          if (a_idx + 3'd1 == len) begin
            state <= S_DONE;
          end else begin
            a_idx <= a_idx + 3'd1;
            a_q   <= a_q + ADDR_WIDTH'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end else begin
      prev_vld <= 1'b0;
    end
  end

  assign if_done_o       = (state == S_DONE) && done_if;
  assign mem_done_o      = (state == S_DONE) && !done_if;
  assign if_stall_req_o  = if_req_i & ~if_done_o;
  assign mem_stall_req_o = mem_req_i & ~mem_done_o;
  assign if_data_o       = if_data_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign ram_a_o         = a_q;
  assign ram_wr_o        = (state == S_MEM_WR) && rdy;
  assign ram_dout_o      = (state == S_MEM_WR) ? wdata[{a_idx[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random loads/stores against a byte-array RAM model.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req_i, if_done_o, if_stall_req_o;
  logic [31:0] if_addr_i, if_data_o;
  logic        mem_req_i, mem_we_i, mem_done_o, mem_stall_req_o;
  logic [2:0]  mem_len_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [39:0] wq [$];
  bit          wr_frozen;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_done_o(if_done_o), .if_stall_req_o(if_stall_req_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .mem_stall_req_o(mem_stall_req_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // n bytes little-endian from a, wrapping at 2^32, zero-extended
  function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = peek(a + 32'(k));
    return v;
  endfunction

  // RAM: one-cycle read latency, write on strobe
  always @(posedge clk) begin
    ram_din_i <= peek(ram_a_o);
    if (ram_wr_o) begin
      if (!rdy) wr_frozen = 1'b1;
      mem[ram_a_o] = ram_dout_o;
      wq.push_back({ram_a_o, ram_dout_o});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit is_mem, input bit we, input logic [2:0] len,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int fr_at, input int fr_len, input bit rnd, input string tag);
    int n, cyc, lows;
    bit got, plain;
    logic [31:0] exp_d;
    n     = is_mem ? int'(len) : 4;
    plain = !rnd && fr_len == 0;
    exp_d = exp_read(addr, n);
    wq.delete();
    wr_frozen = 1'b0;
    lows = 0; got = 1'b0; cyc = 0;
    if (is_mem) begin
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    tick();
    chk({tag, ":stall0"}, 32'(is_mem ? mem_stall_req_o : if_stall_req_o), 32'd1);
    while (cyc < 80) begin
      if (is_mem ? mem_done_o : if_done_o) begin
        got = 1'b1;
        break;
      end
      if (plain && cyc < n) chk({tag, ":addr"}, ram_a_o, addr + 32'(cyc));
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else     rdy = !(cyc >= fr_at && cyc < fr_at + fr_len);
      if (!rdy) lows++;
      tick();
      cyc++;
    end
    rdy = 1'b1;
    chk({tag, ":done"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, ":stall_at_done"}, 32'(is_mem ? mem_stall_req_o : if_stall_req_o), 32'd0);
      if (is_mem && we) begin
        chk({tag, ":lat"}, 32'(cyc), 32'(n + lows));
        chk({tag, ":nwrites"}, 32'(wq.size()), 32'(n));
        for (int k = 0; k < n && k < wq.size(); k++) begin
          chk({tag, ":waddr"}, wq[k][39:8], addr + 32'(k));
          chk({tag, ":wbyte"}, 32'(wq[k][7:0]), 32'(wdata[8*k +: 8]));
        end
        chk({tag, ":wr_frozen"}, 32'(wr_frozen), 32'd0);
      end else begin
        if (lows == 0) chk({tag, ":lat"}, 32'(cyc), 32'(n + 1));
        chk({tag, ":data"}, is_mem ? mem_rdata_o : if_data_o, exp_d);
      end
    end
    if (is_mem) mem_req_i = 1'b0;
    else        if_req_i = 1'b0;
    tick();
    chk({tag, ":pulse"}, 32'(is_mem ? mem_done_o : if_done_o), 32'd0);
  endtask

  initial begin
    int cnt;
    bit seen, mem_first, if_seen;
    logic [31:0] exp_if;
    rst = 1'b1; rdy = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 3'd0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    repeat (3) tick();
    chk("rst:ram_a", ram_a_o, 32'h0);
    chk("rst:ram_wr", 32'(ram_wr_o), 32'd0);
    chk("rst:ram_dout", 32'(ram_dout_o), 32'd0);
    chk("rst:if_data", if_data_o, 32'h0);
    chk("rst:mem_rdata", mem_rdata_o, 32'h0);
    chk("rst:if_done", 32'(if_done_o), 32'd0);
    chk("rst:mem_done", 32'(mem_done_o), 32'd0);
    rst = 1'b0;
    tick();

    mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
    txn(0, 0, 3'd4, 32'h1000, 32'h0, 0, 0, 0, "if1000");
    chk("if1000:word", if_data_o, 32'h00000513);

    txn(1, 1, 3'd4, 32'h20, 32'hDEADBEEF, 0, 0, 0, "st20");
    txn(1, 0, 3'd4, 32'h20, 32'h0, 0, 0, 0, "ld20");
    chk("ld20:word", mem_rdata_o, 32'hDEADBEEF);

    mem[32'h7] = 8'hFF;
    txn(1, 0, 3'd1, 32'h7, 32'h0, 0, 0, 0, "ld7");
    chk("ld7:word", mem_rdata_o, 32'h000000FF);

    txn(1, 1, 3'd4, 32'h80, 32'hA1B2C3D4, 1, 3, 0, "st_freeze");
    txn(1, 0, 3'd4, 32'h80, 32'h0, 2, 3, 0, "ld_freeze");
    txn(1, 0, 3'd4, 32'hFFFFFFFE, 32'h0, 0, 0, 0, "ld_wrap");
    txn(1, 1, 3'd2, 32'hFFFFFFFF, 32'h0000BEEF, 0, 0, 0, "st_wrap");

    // both requests at once: MEM first, IF waits and keeps stalling
    exp_if = exp_read(32'h2000, 4);
    if_req_i = 1'b1; if_addr_i = 32'h2000;
    txn(1, 0, 3'd2, 32'h1000, 32'h0, 0, 0, 0, "prio_mem");
    chk("prio:if_stall", 32'(if_stall_req_o), 32'd1);
    cnt = 0;
    while (!if_done_o && cnt < 20) begin tick(); cnt++; end
    chk("prio:if_lat", 32'(cnt), 32'd6);
    chk("prio:if_data", if_data_o, exp_if);
    if_req_i = 1'b0;
    tick();

    // flush: IF request withdrawn mid-fetch
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    repeat (3) tick();
    if_req_i = 1'b0;
    seen = 1'b0;
    repeat (8) begin tick(); seen |= if_done_o; end
    chk("flush:no_done", 32'(seen), 32'd0);

    // reset in the middle of a fetch
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    repeat (3) tick();
    rst = 1'b1; if_req_i = 1'b0;
    tick();
    chk("rstmid:ram_wr", 32'(ram_wr_o), 32'd0);
    chk("rstmid:ram_a", ram_a_o, 32'h0);
    chk("rstmid:if_data", if_data_o, 32'h0);
    rst = 1'b0;
    seen = if_done_o;
    repeat (6) begin tick(); seen |= if_done_o; end
    chk("rstmid:no_done", 32'(seen), 32'd0);

`ifdef MEMCTRL_IF_ABORT_EN
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    tick();
    tick();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 3'd4; mem_addr_i = 32'h40; mem_wdata_i = 32'h11223344;
    seen = 1'b0; if_seen = 1'b0; mem_first = 1'b0; cnt = 0;
    while (!if_seen && cnt < 40) begin
      tick(); cnt++;
      if (mem_done_o) begin seen = 1'b1; mem_req_i = 1'b0; end
      if (if_done_o) begin
        if_seen = 1'b1; mem_first = seen;
        chk("abort:if_data", if_data_o, 32'h00000513);
        if_req_i = 1'b0;
      end
    end
    chk("abort:if_done", 32'(if_seen), 32'd1);
    chk("abort:mem_first", 32'(mem_first), 32'd1);
    mem_req_i = 1'b0; if_req_i = 1'b0;
    tick();
`endif

    for (int i = 0; i < 24; i++) begin
      bit          r_mem, r_we, r_rnd;
      logic [2:0]  r_len;
      logic [31:0] r_addr;
      int          sel;
      r_mem = ($urandom_range(0, 2) != 0);
      r_we  = $urandom_range(0, 1) != 0;
      sel   = $urandom_range(0, 2);
      r_len = (sel == 0) ? 3'd1 : (sel == 1) ? 3'd2 : 3'd4;
      r_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                           : 32'($urandom_range(0, 255));
      r_rnd = $urandom_range(0, 1) != 0;
      txn(r_mem, r_we, r_len, r_addr, $urandom, 0, 0, r_rnd, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
